// File: rtl/clkdiv_if.sv
// rtl/clkdiv_if.sv - control and status bundle for the clock divider
interface clkdiv_if #(
  parameter int unsigned CNT_W = 32
);
  logic             en;
  logic             busy;
  logic             clk_div;
  logic [CNT_W-1:0] clkcount;

  modport master (
    output en,
    output busy,
    input  clk_div,
    input  clkcount
  );

  modport slave (
    input  en,
    input  busy,
    output clk_div,
    output clkcount
  );
endinterface

// File: rtl/clkdiv.sv
// rtl/clkdiv.sv - programmable even clock divider with saturating run-length counter
module clkdiv #(
  parameter int unsigned DIV   = 4,
  parameter int unsigned CNT_W = 32
) (
  input  logic     clk,
  input  logic     rst,
  clkdiv_if.slave  bus
);
  // Last phase index of each half period; the divided clock toggles when ph reaches it.
  localparam logic [31:0] HALF_M1 = 32'(DIV / 2 - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  // Declaration values give a clean start even when rst is never asserted.
  logic [31:0]      ph_q       = '0;
  logic             clk_div_q  = 1'b0;
  logic [CNT_W-1:0] clkcount_q = '0;

  logic [31:0]      ph_d;
  logic             clk_div_d;
  logic [CNT_W-1:0] clkcount_d;
  logic             active;

  // Next-state: run the phase counter while enabled and busy, otherwise park low at phase 0.
  always_comb begin
    active     = bus.en & bus.busy;
    ph_d       = ph_q;
    clk_div_d  = clk_div_q;
    clkcount_d = clkcount_q;
    if (!active) begin
      ph_d      = '0;
      clk_div_d = 1'b0;
    end else if (ph_q == HALF_M1) begin
      ph_d      = '0;
      clk_div_d = ~clk_div_q;
      // Count only rising edges, and hold at all-ones instead of wrapping.
      if (!clk_div_q && (clkcount_q != CNT_MAX)) begin
        clkcount_d = clkcount_q + CNT_ONE;
      end
    end else begin
      ph_d = ph_q + 32'd1;
    end
  end

  // State registers with synchronous reset taking priority over activity.
  always_ff @(posedge clk) begin
    if (rst) begin
      ph_q       <= '0;
      clk_div_q  <= 1'b0;
      clkcount_q <= '0;
    end else begin
      ph_q       <= ph_d;
      clk_div_q  <= clk_div_d;
      clkcount_q <= clkcount_d;
    end
  end

  assign bus.clk_div  = clk_div_q;
  assign bus.clkcount = clkcount_q;
endmodule

// File: tb/tb_clkdiv.sv
// tb/tb_clkdiv.sv - table and scoreboard bench for clkdiv at DIV=4 and DIV=2
module tb_clkdiv;
  logic clk = 1'b0;
  logic rst = 1'b0;

  clkdiv_if #(.CNT_W(32)) bus4 ();
  clkdiv_if #(.CNT_W(32)) bus2 ();

  clkdiv #(.DIV(4), .CNT_W(32)) dut4 (.clk(clk), .rst(rst), .bus(bus4.slave));
  clkdiv #(.DIV(2), .CNT_W(32)) dut2 (.clk(clk), .rst(rst), .bus(bus2.slave));

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        en;
    logic        busy;
    logic        exp_div;
    logic [31:0] exp_cnt;
  } vec_t;

  typedef struct {
    logic        div;
    logic [31:0] cnt;
    int          tag;
  } exp_t;

  vec_t vecs[$];
  exp_t sb4[$];
  exp_t sb2[$];
  int   errors = 0;
  int   checks = 0;

  task automatic chk(input string name, input int tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d]: got %0h expected %0h", name, tag, act, exp);
    end
  endtask

  function automatic void add(input logic r, input logic e, input logic b, input logic d, input logic [31:0] c);
    vec_t v;
    v.rst = r; v.en = e; v.busy = b; v.exp_div = d; v.exp_cnt = c;
    vecs.push_back(v);
  endfunction

  // Drive one edge's inputs at the falling edge, optionally queue expectations, then compare after the rising edge.
  task automatic step(input logic r, input logic e, input logic b, input int tag,
                      input logic push4, input logic d4, input logic [31:0] c4,
                      input logic push2, input logic d2, input logic [31:0] c2);
    exp_t x;
    @(negedge clk);
    rst = r;
    bus4.en = e; bus4.busy = b;
    bus2.en = e; bus2.busy = b;
    if (push4) begin x.div = d4; x.cnt = c4; x.tag = tag; sb4.push_back(x); end
    if (push2) begin x.div = d2; x.cnt = c2; x.tag = tag; sb2.push_back(x); end
    @(posedge clk);
    #1;
    if (push4) begin
      if (sb4.size() == 0) chk("sb4_empty", tag, 32'd0, 32'd1);
      else begin
        x = sb4.pop_front();
        chk("div4_clk_div", x.tag, {31'd0, bus4.clk_div}, {31'd0, x.div});
        chk("div4_clkcount", x.tag, bus4.clkcount, x.cnt);
      end
    end
    if (push2) begin
      if (sb2.size() == 0) chk("sb2_empty", tag, 32'd0, 32'd1);
      else begin
        x = sb2.pop_front();
        chk("div2_clk_div", x.tag, {31'd0, bus2.clk_div}, {31'd0, x.div});
        chk("div2_clkcount", x.tag, bus2.clkcount, x.cnt);
      end
    end
  endtask

  initial begin
    bus4.en = 1'b0; bus4.busy = 1'b1;
    bus2.en = 1'b0; bus2.busy = 1'b1;

    // Power-up without reset: outputs known and zero.
    #30;
    chk("pwr_x4", 0, {31'd0, $isunknown({bus4.clk_div, bus4.clkcount})}, 32'd0);
    chk("pwr_x2", 0, {31'd0, $isunknown({bus2.clk_div, bus2.clkcount})}, 32'd0);
    chk("pwr_div4", 0, {31'd0, bus4.clk_div}, 32'd0);
    chk("pwr_cnt4", 0, bus4.clkcount, 32'd0);
    chk("pwr_div2", 0, {31'd0, bus2.clk_div}, 32'd0);
    chk("pwr_cnt2", 0, bus2.clkcount, 32'd0);

    // DIV=4 vectors: rst, en, busy, expected clk_div, expected clkcount after the edge.
    add(0,1,1, 0,0);  add(0,1,1, 1,1);  add(0,1,1, 1,1);  add(0,1,1, 0,1);
    add(0,1,1, 0,1);  add(0,1,1, 1,2);  add(0,1,1, 1,2);
    add(0,0,1, 0,2);  add(0,0,1, 0,2);  add(0,0,1, 0,2);
    add(0,1,1, 0,2);  add(0,1,1, 1,3);  add(0,1,1, 1,3);
    add(0,1,0, 0,3);  add(0,1,0, 0,3);  add(0,1,0, 0,3);
    add(0,1,0, 0,3);  add(0,1,0, 0,3);  add(0,1,0, 0,3);
    add(0,1,1, 0,3);  add(0,1,1, 1,4);  add(0,1,1, 1,4);
    add(1,1,1, 0,0);  add(0,1,1, 0,0);  add(0,1,1, 1,1);
    add(0,0,1, 0,1);  add(0,1,0, 0,1);  add(0,0,0, 0,1);
    add(0,1,1, 0,1);  add(0,1,1, 1,2);  add(1,0,0, 0,0);

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].rst, vecs[i].en, vecs[i].busy, i,
           1'b1, vecs[i].exp_div, vecs[i].exp_cnt, 1'b0, 1'b0, 32'd0);
    end

    // Reset both instances, then run 50 continuous active edges against closed-form expectations.
    step(1'b1, 1'b0, 1'b0, 100, 1'b1, 1'b0, 32'd0, 1'b1, 1'b0, 32'd0);
    for (int n = 1; n <= 50; n++) begin
      step(1'b0, 1'b1, 1'b1, 100 + n,
           1'b1, logic'(((n / 2) % 2) == 1), 32'((n + 2) / 4),
           1'b1, logic'((n % 2) == 1), 32'((n + 1) / 2));
    end
    chk("run50_cnt4", 50, bus4.clkcount, 32'd13);
    chk("run50_cnt2", 50, bus2.clkcount, 32'd25);

    // Stop via busy and confirm the count stays frozen over several edges.
    for (int n = 0; n < 6; n++) begin
      step(1'b0, 1'b1, 1'b0, 200 + n, 1'b1, 1'b0, 32'd13, 1'b1, 1'b0, 32'd25);
    end

    // Re-activation restarts the phase but continues the held count.
    step(1'b0, 1'b1, 1'b1, 300, 1'b1, 1'b0, 32'd13, 1'b1, 1'b1, 32'd26);
    step(1'b0, 1'b1, 1'b1, 301, 1'b1, 1'b1, 32'd14, 1'b1, 1'b0, 32'd26);

    chk("sb4_drained", 0, sb4.size(), 32'd0);
    chk("sb2_drained", 0, sb2.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
